// File: rtl/cabac_pkg.sv
// Shared types and constants for the arithmetic decoder value path.
package cabac_pkg;
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INIT_HI,
      ST_INIT_LO,
      ST_RUN
   } refill_state_t;

   localparam logic signed [3:0] BITS_NEEDED_INIT = -4'sd8;
   localparam int BYTE_W = 8;
endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO; registered read side, no write-to-read bypass.
module byte_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     flush
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign push_ready = (count != FULL);
   assign do_push    = push_valid && push_ready;
   assign do_pop     = pop && (count != '0);
   assign pop_data   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   // flush wins over any push or pop in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/value_refill_unit.sv
// Registered decoder value with per-command shift and automatic byte refill.
module value_refill_unit
   import cabac_pkg::*;
#(
   parameter int VALUE_W    = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int SHIFT_W    = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               byte_valid,
   output logic               byte_ready,
   input  logic [7:0]         byte_data,
   input  logic               flush,
   input  logic               init_req,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [SHIFT_W-1:0] cmd_shift,
   output logic [VALUE_W-1:0] value_out,
   output logic [3:0]         bits_needed_out,
   output logic               value_valid
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   refill_state_t       state;
   refill_state_t       state_nx;
   logic [VALUE_W-1:0]  value_q;
   logic [VALUE_W-1:0]  value_nx;
   logic signed [3:0]   bn_q;
   logic signed [3:0]   bn_nx;
   logic [BYTE_W-1:0]   hi_q;
   logic [BYTE_W-1:0]   hi_nx;
   logic [BYTE_W-1:0]   fifo_data;
   logic [CW-1:0]       fifo_count;
   logic                fifo_pop;
   logic                fifo_nonempty;
   logic signed [4:0]   n;
   logic                need_byte;
   logic                cmd_fire;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (BYTE_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (byte_valid),
      .push_ready (byte_ready),
      .push_data  (byte_data),
      .pop        (fifo_pop),
      .pop_data   (fifo_data),
      .count      (fifo_count),
      .flush      (flush)
   );

   assign fifo_nonempty = (fifo_count != '0);
   assign n             = {bn_q[3], bn_q} + 5'(cmd_shift);
   assign need_byte     = ~n[4];
   assign cmd_ready     = (state == ST_RUN) && !init_req
                        && (!need_byte || fifo_nonempty);
   assign cmd_fire      = cmd_valid && cmd_ready;

   assign value_out       = value_q;
   assign bits_needed_out = bn_q;
   assign value_valid     = (state == ST_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         value_q <= '0;
         bn_q    <= BITS_NEEDED_INIT;
         hi_q    <= '0;
      end else begin
         state   <= state_nx;
         value_q <= value_nx;
         bn_q    <= bn_nx;
         hi_q    <= hi_nx;
      end
   end

   always_comb begin
      state_nx = state;
      value_nx = value_q;
      bn_nx    = bn_q;
      hi_nx    = hi_q;
      fifo_pop = 1'b0;
      if (init_req) begin
         state_nx = ST_INIT_HI;
         value_nx = '0;
         bn_nx    = BITS_NEEDED_INIT;
      end else begin
         unique case (state)
            ST_INIT_HI: begin
               if (fifo_nonempty) begin
                  fifo_pop = 1'b1;
                  hi_nx    = fifo_data;
                  state_nx = ST_INIT_LO;
               end
            end
            ST_INIT_LO: begin
               if (fifo_nonempty) begin
                  fifo_pop = 1'b1;
                  value_nx = VALUE_W'({hi_q, fifo_data});
                  bn_nx    = BITS_NEEDED_INIT;
                  state_nx = ST_RUN;
               end
            end
            ST_RUN: begin
               if (cmd_fire) begin
                  value_nx = value_q << cmd_shift;
                  // n is 0..6 here, so the byte lands fully inside the value
                  if (need_byte) begin
                     fifo_pop = 1'b1;
                     value_nx = value_nx
                              + (VALUE_W'(fifo_data) << n[2:0]);
                     bn_nx    = n[3:0] + 4'sd8;
                  end else begin
                     bn_nx = n[3:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_value_refill_unit.sv
// Self-checking bench: reference model of the value refill unit plus directed and random stimulus.
module tb_value_refill_unit;
   import cabac_pkg::*;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        byte_valid;
   logic        byte_ready;
   logic [7:0]  byte_data;
   logic        flush;
   logic        init_req;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_shift;
   logic [15:0] value_out;
   logic [3:0]  bits_needed_out;
   logic        value_valid;

   int checks;
   int failures;

   // reference model: phase 0 idle, 1 wait hi, 2 wait lo, 3 run
   int m_phase;
   int m_val;
   int m_bn;
   int m_b0;
   int m_q[$];

   value_refill_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .byte_valid      (byte_valid),
      .byte_ready      (byte_ready),
      .byte_data       (byte_data),
      .flush           (flush),
      .init_req        (init_req),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_shift       (cmd_shift),
      .value_out       (value_out),
      .bits_needed_out (bits_needed_out),
      .value_valid     (value_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)",
                  name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      if (rst_n && cmd_valid)
         assert (cmd_shift != 3'd0)
            else $error("illegal zero shift offered");
   end

   // model-based compare on every falling edge, then model advance
   always @(negedge clk) begin
      int sz;
      int n;
      int s;
      bit exp_cr;
      bit exp_br;
      if (!rst_n) begin
         m_phase = 0;
         m_val   = 0;
         m_bn    = -8;
         m_q.delete();
      end
      sz     = m_q.size();
      s      = int'(cmd_shift);
      n      = m_bn + s;
      exp_br = (sz < DEPTH);
      exp_cr = rst_n && (m_phase == 3) && !init_req && (n < 0 || sz > 0);
      check("m_value", int'(value_out), m_val);
      check("m_bits_needed", int'($signed(bits_needed_out)), m_bn);
      check("m_value_valid", int'(value_valid), int'(m_phase == 3));
      check("m_cmd_ready", int'(cmd_ready), int'(exp_cr));
      check("m_byte_ready", int'(byte_ready), int'(exp_br));
      if (rst_n) begin
         if (init_req) begin
            m_phase = 1;
            m_val   = 0;
            m_bn    = -8;
         end else if (m_phase == 1 && sz > 0) begin
            m_b0    = m_q.pop_front();
            m_phase = 2;
         end else if (m_phase == 2 && sz > 0) begin
            m_val   = m_b0 * 256 + m_q.pop_front();
            m_bn    = -8;
            m_phase = 3;
         end else if (m_phase == 3 && cmd_valid && exp_cr) begin
            m_val = (m_val * (1 << s)) % 65536;
            if (n >= 0) begin
               m_val = (m_val + m_q.pop_front() * (1 << n)) % 65536;
               m_bn  = n - 8;
            end else begin
               m_bn = n;
            end
         end
         if (flush) m_q.delete();
         else if (byte_valid && exp_br) m_q.push_back(int'(byte_data));
      end
   end

   initial begin
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      flush      = 1'b0;
      init_req   = 1'b0;
      cmd_valid  = 1'b0;
      cmd_shift  = 3'd1;
      repeat (3) tick();
      rst_n = 1'b1;
      #1;
      check("rst_value_valid", int'(value_valid), 0);
      check("rst_bits_needed", int'($signed(bits_needed_out)), -8);
      check("rst_cmd_ready", int'(cmd_ready), 0);
      check("rst_byte_ready", int'(byte_ready), 1);

      // init load from two buffered bytes
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      tick();
      byte_data  = 8'h3C;
      tick();
      byte_valid = 1'b0;
      init_req   = 1'b1;
      tick();
      init_req   = 1'b0;
      tick();
      tick();
      check("init_value", int'(value_out), 16'hA53C);
      check("init_bn", int'($signed(bits_needed_out)), -8);
      check("init_valid", int'(value_valid), 1);

      // shift without refill
      cmd_valid = 1'b1;
      cmd_shift = 3'd3;
      #1;
      check("s3_ready", int'(cmd_ready), 1);
      tick();
      cmd_valid = 1'b0;
      check("s3_value", int'(value_out), 16'h29E0);
      check("s3_bn", int'($signed(bits_needed_out)), -5);

      // shift with refill
      byte_valid = 1'b1;
      byte_data  = 8'hFF;
      tick();
      byte_valid = 1'b0;
      cmd_valid  = 1'b1;
      cmd_shift  = 3'd6;
      #1;
      check("s6_ready", int'(cmd_ready), 1);
      tick();
      check("s6_value", int'(value_out), 16'h79FE);
      check("s6_bn", int'($signed(bits_needed_out)), -7);
      check("s6_count", int'(dut.u_fifo.count), 0);
      tick();
      cmd_valid = 1'b0;
      check("s6b_value", int'(value_out), 16'h7F80);
      check("s6b_bn", int'($signed(bits_needed_out)), -1);

      // bypass starvation
      cmd_valid = 1'b1;
      cmd_shift = 3'd1;
      #1;
      check("starve_ready0", int'(cmd_ready), 0);
      tick();
      check("starve_ready1", int'(cmd_ready), 0);
      byte_valid = 1'b1;
      byte_data  = 8'h12;
      #1;
      check("starve_ready2", int'(cmd_ready), 0);
      tick();
      byte_valid = 1'b0;
      #1;
      check("starve_ready3", int'(cmd_ready), 1);
      tick();
      cmd_valid = 1'b0;
      check("starve_value", int'(value_out), 16'hFF12);
      check("starve_bn", int'($signed(bits_needed_out)), -8);

      // fill to full, pop with blocked push, then flush
      byte_valid = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         byte_data = 8'(8'h11 * (k + 1));
         tick();
      end
      byte_valid = 1'b0;
      #1;
      check("full_byte_ready", int'(byte_ready), 0);
      cmd_valid = 1'b1;
      cmd_shift = 3'd7;
      tick();
      check("s7_value", int'(value_out), 16'h8900);
      check("s7_bn", int'($signed(bits_needed_out)), -1);
      cmd_shift  = 3'd1;
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      #1;
      check("full_pop_ready", int'(cmd_ready), 1);
      check("full_push_ready", int'(byte_ready), 0);
      tick();
      cmd_valid  = 1'b0;
      byte_valid = 1'b0;
      check("full_pop_value", int'(value_out), 16'h1211);
      check("full_pop_bn", int'($signed(bits_needed_out)), -8);
      check("full_pop_count", int'(dut.u_fifo.count), 3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_count", int'(dut.u_fifo.count), 0);
      check("flush_value", int'(value_out), 16'h1211);

      // async reset during a stalled command
      cmd_valid = 1'b1;
      cmd_shift = 3'd7;
      tick();
      cmd_shift  = 3'd1;
      byte_valid = 1'b1;
      byte_data  = 8'h77;
      tick();
      byte_valid = 1'b0;
      rst_n      = 1'b0;
      #1;
      check("arst_value", int'(value_out), 0);
      check("arst_bn", int'($signed(bits_needed_out)), -8);
      check("arst_valid", int'(value_valid), 0);
      check("arst_cmd_ready", int'(cmd_ready), 0);
      check("arst_byte_ready", int'(byte_ready), 1);
      tick();
      rst_n     = 1'b1;
      cmd_valid = 1'b0;
      #1;
      check("arst_count", int'(dut.u_fifo.count), 0);
      check("arst_state", int'(dut.state), int'(ST_IDLE));

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         byte_valid = ($urandom_range(0, 99) < 60);
         byte_data  = 8'($urandom);
         flush      = ($urandom_range(0, 199) == 0);
         init_req   = ($urandom_range(0, 149) == 0) || (i == 2) || (i == 1503);
         cmd_valid  = ($urandom_range(0, 99) < 50);
         cmd_shift  = 3'($urandom_range(1, 7));
         if (i == 1500) rst_n = 1'b0;
         if (i == 1501) rst_n = 1'b1;
         tick();
      end
      byte_valid = 1'b0;
      flush      = 1'b0;
      init_req   = 1'b0;
      cmd_valid  = 1'b0;
      repeat (3) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/value_refill_unit.md
# value_refill_unit

Sequential successor to the combinational byte-insert path of the arithmetic decoder. It owns the registered decoder value (`m_value`) and the signed `bitsNeeded` counter, buffers incoming bitstream bytes in a small FIFO, and applies per-command left shifts with automatic byte insertion. It sits between the bitstream fetch and the bin decode engines (regular and bypass), and stalls a command when a byte is needed but the FIFO is empty.

## Interface
Parameters:
- `VALUE_W`, 16, width of `m_value`; must be ≥ 16.
- `FIFO_DEPTH`, 4, byte FIFO entries; power of two, ≥ 2.
- `SHIFT_W`, 3, width of the shift amount; legal shifts are 1..7.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `byte_valid`  in  1  bitstream byte offered.
- `byte_ready`  out  1  FIFO not full.
- `byte_data`  in  8  bitstream byte.
- `flush`  in  1  one-cycle pulse; empties the FIFO.
- `init_req`  in  1  one-cycle pulse; restarts the value load.
- `cmd_valid`  in  1  shift command offered.
- `cmd_ready`  out  1  command accepted this cycle when high with `cmd_valid`.
- `cmd_shift`  in  `SHIFT_W`  shift amount s (renorm count, or 1 for a bypass bin).
- `value_out`  out  `VALUE_W`  registered `m_value`.
- `bits_needed_out`  out  4  signed registered `bitsNeeded`.
- `value_valid`  out  1  high only in RUN.

## Operation
- States: IDLE, INIT_HI, INIT_LO, RUN.
- Reset:
  - state = IDLE; FIFO empty.
  - `value_out` = 0; `bits_needed_out` = -8.
  - `value_valid` = 0; `cmd_ready` = 0; `byte_ready` = 1.
- `init_req` in any state:
  - next state is INIT_HI.
  - value cleared to 0; `bits_needed` = -8.
  - any pending command is not accepted.
- INIT_HI: pop byte b0 when the FIFO is non-empty, then go to INIT_LO.
- INIT_LO: pop byte b1, set value = {b0, b1} zero-extended to `VALUE_W`, `bits_needed` = -8, then go to RUN.
- RUN, on command accept with shift s:
  - n = bits_needed + s, a 5-bit signed intermediate.
  - value_next = (value << s) mod 2^VALUE_W.
  - If n ≥ 0: pop one byte, value_next += byte << n (mod 2^VALUE_W), bits_needed_next = n − 8.
  - Else: bits_needed_next = n; no pop.
  - Because bits_needed ∈ [-8,-1] and s ∈ [1,7], n ∈ [-7,6]. At most one byte is needed per command.
- `cmd_ready` = (state == RUN) && !init_req && (n < 0 || fifo_count > 0).
  - This is combinational on `cmd_shift`.
- `cmd_shift` = 0 is illegal. Behaviour is undefined; the bench must flag it with an assertion.
- FIFO:
  - `byte_ready` = !full.
  - Push and pop in the same cycle are allowed when not full and not empty.
  - A push while full is not possible, because ready is low even if a pop occurs that cycle.
  - An empty FIFO never forwards the incoming byte combinationally. A byte written in cycle t is poppable from t+1.
- `flush`:
  - clears FIFO count and pointers; a push in the same cycle is dropped.
  - does not change state, value or bits_needed.
- `flush` together with `init_req`: both take effect.

## Timing
- Command accepted in cycle t → `value_out` and `bits_needed_out` update on the clock edge ending cycle t.
- Back-to-back commands are sustained at one per cycle while bytes are available.
- INIT: with the FIFO holding ≥ 2 bytes, RUN and `value_valid` are reached 2 cycles after `init_req`.
- Starvation:
  - `cmd_ready` stays low while n ≥ 0 and the FIFO is empty.
  - A byte pushed in cycle t allows acceptance in t+1 at the earliest.
- Asynchronous reset mid-operation returns everything to the reset values immediately. Bytes in the FIFO are lost.

## Structure
- Shared package `cabac_pkg`:
  - state enum `refill_state_t`.
  - constant `BITS_NEEDED_INIT` = -8.
  - constant `BYTE_W` = 8.
- Sub-module `byte_fifo`:
  - parameters `DEPTH` and `W`.
  - ports: valid/ready push, pop strobe, `count`, `flush`.
- The shift/insert datapath stays inline.

## Test plan
- Reset then IDLE: `value_valid`=0, `bits_needed_out`=-8, `cmd_ready`=0, `byte_ready`=1.
- Push 0xA5, 0x3C, pulse `init_req` → value 0xA53C, bits_needed -8, `value_valid`=1 two cycles later.
- From 0xA53C/-8, cmd s=3 → value 0x29E0, bn -5, no pop. Then FIFO holds 0xFF; cmd s=6 → value 0x79FE, bn -7, FIFO count decremented.
- Bypass starvation at bn -1 with the FIFO empty, cmd s=1:
  - `cmd_ready` = 0 until a byte 0x12 is pushed.
  - Accepted the next cycle: value = (v<<1)+0x12, bn -8.
- Fill the FIFO to `FIFO_DEPTH` → `byte_ready`=0.
  - Simultaneous pop and offered push: push is not taken.
  - `flush` → count 0, value unchanged.
- Assert `rst_n` low during a stalled command with a non-empty FIFO → all outputs return to reset values asynchronously; after release, the FIFO is empty and the state is IDLE.
